serial_config_shifter: RTL and testbench

//  Downstream stage of the I2C register bank: snapshots configuration bytes on a start request and

---
 rtl/serial_config_shifter.sv | 194 +++++++++++++++++++
 tb/tb_serial_config_shifter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_config_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_config_shifter
//  Description : Snapshots configuration bytes when start_reg[0] rises and
//                programs the TDC chip over its 4-wire serial config port:
//                a reset pulse, then 8*NBYTES bits MSB-first (byte 0 first),
//                then one capture strobe. All pad outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_config_shifter #(
    parameter int CLK_DIV     = 8,   // clkin cycles per sck half-period (>=2)
    parameter int NBYTES      = 12,  // config bytes shifted per program
    parameter int RESET_TICKS = 4    // half-periods of p_reset before shifting (>=1)
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic [7:0]            start_reg,
    input  logic [8*NBYTES-1:0]   cfg_data,
    output logic                  p_sck,
    output logic                  p_sda,
    output logic                  p_scapt,
    output logic                  p_reset,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            prog_count
);

    localparam int c_nbits = 8 * NBYTES;
    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_bit_w = $clog2(c_nbits);
    localparam int c_ph_w  = (RESET_TICKS > 1) ? $clog2(RESET_TICKS) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_nbits - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(RESET_TICKS - 1);
    // XOR with 7 turns the in-byte bit number into 7-(n%8), giving MSB-first order
    localparam logic [c_bit_w-1:0] c_bit_flip = c_bit_w'(7);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESET    = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_CAPTURE  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                 state_q,      state_d;
    logic [c_div_w-1:0]     div_q,        div_d;
    logic [c_bit_w-1:0]     bitcnt_q,     bitcnt_d;
    logic [c_ph_w-1:0]      phcnt_q,      phcnt_d;
    logic [c_nbits-1:0]     shadow_q,     shadow_d;
    logic [7:0]             prog_count_q, prog_count_d;
    logic                   start_q,      start_d;
    logic                   sck_q,        sck_d;
    logic                   sda_q,        sda_d;
    logic                   scapt_q,      scapt_d;
    logic                   preset_q,     preset_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;

    logic                   w_req;
    logic                   w_tick;
    logic [c_bit_w-1:0]     w_sda_idx;

    // Only bit 0 of the control register is meaningful
    logic                   unused_start_bits;
    assign unused_start_bits = ^start_reg[7:1];

    assign w_req     = start_reg[0] & ~start_q;
    assign w_tick    = (div_q == c_div_last);

    // Next-state, counters, and next values of the registered pad outputs
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bitcnt_d     = bitcnt_q;
        phcnt_d      = phcnt_q;
        shadow_d     = shadow_q;
        prog_count_d = prog_count_q;
        start_d      = start_reg[0];

        // Divider free-runs while a frame is active and rests at 0 in IDLE
        if (state_q == S_IDLE) begin
            div_d = '0;
        end else if (w_tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    shadow_d = cfg_data;
                    bitcnt_d = '0;
                    phcnt_d  = '0;
                    state_d  = S_RESET;
                end
            end
            S_RESET: begin
                if (w_tick) begin
                    if (phcnt_q == c_ph_last) begin
                        state_d = S_SHIFT_LO;
                    end else begin
                        phcnt_d = phcnt_q + 1'b1;
                    end
                end
            end
            S_SHIFT_LO: begin
                if (w_tick) begin
                    state_d = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_tick) begin
                    if (bitcnt_q == c_bit_last) begin
                        state_d = S_CAPTURE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        state_d  = S_SHIFT_LO;
                    end
                end
            end
            S_CAPTURE: begin
                // Count the program as it enters DONE so the count is
                // already updated while the done pulse is visible
                if (w_tick) begin
                    state_d      = S_DONE;
                    prog_count_d = prog_count_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pads are decoded from the next state so they change together with it
        w_sda_idx = bitcnt_d ^ c_bit_flip;
        sck_d     = (state_d == S_SHIFT_HI);
        sda_d     = ((state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI)) ? shadow_d[w_sda_idx] : 1'b0;
        scapt_d   = (state_d == S_CAPTURE);
        preset_d  = (state_d == S_RESET);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any frame without a capture strobe
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            bitcnt_q     <= '0;
            phcnt_q      <= '0;
            shadow_q     <= '0;
            prog_count_q <= '0;
            start_q      <= 1'b1;
            sck_q        <= 1'b0;
            sda_q        <= 1'b0;
            scapt_q      <= 1'b0;
            preset_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bitcnt_q     <= bitcnt_d;
            phcnt_q      <= phcnt_d;
            shadow_q     <= shadow_d;
            prog_count_q <= prog_count_d;
            start_q      <= start_d;
            sck_q        <= sck_d;
            sda_q        <= sda_d;
            scapt_q      <= scapt_d;
            preset_q     <= preset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign p_sck      = sck_q;
    assign p_sda      = sda_q;
    assign p_scapt    = scapt_q;
    assign p_reset    = preset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign prog_count = prog_count_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_config_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_config_shifter
//  Description : Scoreboard bench. Stimulus pushes expected serial bits and
//                per-frame results; monitors pop and compare on sck rising
//                edges and done pulses. DUT a uses default parameters, DUT b
//                a minimal configuration for short and wrap-around frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_config_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  start_a, start_b;
    logic [95:0] cfg_a;
    logic [7:0]  cfg_b;
    logic        sck_a, sda_a, scapt_a, preset_a, busy_a, done_a;
    logic        sck_b, sda_b, scapt_b, preset_b, busy_b, done_b;
    logic [7:0]  cnt_a, cnt_b;

    serial_config_shifter #(.CLK_DIV(8), .NBYTES(12), .RESET_TICKS(4)) dut_a (
        .clkin(clk), .rst(rst), .start_reg(start_a), .cfg_data(cfg_a),
        .p_sck(sck_a), .p_sda(sda_a), .p_scapt(scapt_a), .p_reset(preset_a),
        .busy(busy_a), .done(done_a), .prog_count(cnt_a)
    );

    serial_config_shifter #(.CLK_DIV(2), .NBYTES(1), .RESET_TICKS(1)) dut_b (
        .clkin(clk), .rst(rst), .start_reg(start_b), .cfg_data(cfg_b),
        .p_sck(sck_b), .p_sda(sda_b), .p_scapt(scapt_b), .p_reset(preset_b),
        .busy(busy_b), .done(done_b), .prog_count(cnt_b)
    );

    typedef struct {
        int         busy_len;
        int         reset_len;
        int         scapt_len;
        int         nbits;
        logic [7:0] count;
        logic [7:0] byte_val;
    } frame_t;

    frame_t exp_a[$];
    frame_t exp_b[$];
    logic   exp_bits_a[$];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitor for DUT a ----------------
    logic   sck_a_prev = 1'b0, busy_a_prev = 1'b0, bit_a;
    int     a_busy = 0, a_rst = 0, a_scapt = 0, a_bits = 0, a_scapt_total = 0;
    frame_t fa;

    always @(negedge clk) begin
        if (busy_a && !busy_a_prev) begin
            a_busy = 0; a_rst = 0; a_scapt = 0; a_bits = 0;
        end
        if (busy_a)   a_busy++;
        if (preset_a) a_rst++;
        if (scapt_a) begin a_scapt++; a_scapt_total++; end
        if (sck_a && !sck_a_prev) begin
            a_bits++;
            if (exp_bits_a.size() == 0) fail_now("a_spurious_sck_edge");
            else begin
                bit_a = exp_bits_a.pop_front();
                check("a_sda_at_sck_rise", sda_a, bit_a);
            end
        end
        if (done_a) begin
            if (exp_a.size() == 0) fail_now("a_spurious_done");
            else begin
                fa = exp_a.pop_front();
                check("a_busy_cycles", a_busy, fa.busy_len);
                check("a_reset_cycles", a_rst, fa.reset_len);
                check("a_scapt_cycles", a_scapt, fa.scapt_len);
                check("a_bit_count", a_bits, fa.nbits);
                check("a_prog_count", cnt_a, fa.count);
            end
        end
        sck_a_prev  = sck_a;
        busy_a_prev = busy_a;
    end

    // ---------------- monitor for DUT b ----------------
    logic       sck_b_prev = 1'b0, busy_b_prev = 1'b0;
    logic [7:0] b_shift = 8'h00;
    int         b_busy = 0, b_rst = 0, b_scapt = 0, b_bits = 0, b_done_total = 0;
    frame_t     fb;

    always @(negedge clk) begin
        if (busy_b && !busy_b_prev) begin
            b_busy = 0; b_rst = 0; b_scapt = 0; b_bits = 0; b_shift = 8'h00;
        end
        if (busy_b)   b_busy++;
        if (preset_b) b_rst++;
        if (scapt_b)  b_scapt++;
        if (sck_b && !sck_b_prev) begin
            b_bits++;
            b_shift = {b_shift[6:0], sda_b};
        end
        if (done_b) begin
            b_done_total++;
            if (exp_b.size() == 0) fail_now("b_spurious_done");
            else begin
                fb = exp_b.pop_front();
                check("b_busy_cycles", b_busy, fb.busy_len);
                check("b_reset_cycles", b_rst, fb.reset_len);
                check("b_scapt_cycles", b_scapt, fb.scapt_len);
                check("b_bit_count", b_bits, fb.nbits);
                check("b_shifted_byte", b_shift, fb.byte_val);
                check("b_prog_count", cnt_b, fb.count);
            end
        end
        sck_b_prev  = sck_b;
        busy_b_prev = busy_b;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame_a(input logic [95:0] cfg, input logic [7:0] cnt);
        frame_t f;
        for (int k = 0; k < 12; k++)
            for (int b = 7; b >= 0; b--)
                exp_bits_a.push_back(cfg[8*k + b]);
        f.busy_len = 1577; f.reset_len = 32; f.scapt_len = 8; f.nbits = 96;
        f.count = cnt; f.byte_val = 8'h00;
        exp_a.push_back(f);
    endtask

    task automatic push_frame_b(input logic [7:0] cnt);
        frame_t f;
        f.busy_len = 37; f.reset_len = 2; f.scapt_len = 2; f.nbits = 8;
        f.count = cnt; f.byte_val = 8'h81;
        exp_b.push_back(f);
    endtask

    task automatic wait_a_done(input int limit);
        int k = 0;
        while (exp_a.size() != 0 && k < limit) begin @(negedge clk); k++; end
        if (exp_a.size() != 0) begin
            fail_now("a_frame_timeout");
            exp_a.delete();
            exp_bits_a.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done_b(input int limit);
        int k = 0;
        while (!done_b && k < limit) begin @(negedge clk); k++; end
        if (!done_b) fail_now("b_done_timeout");
    endtask

    task automatic pulse_a;
        start_a[0] = 1'b1; @(negedge clk); start_a[0] = 1'b0;
    endtask

    task automatic pulse_b;
        start_b[0] = 1'b1; @(negedge clk); start_b[0] = 1'b0;
    endtask

    // Watchdog so a hung design still ends the run
    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    int scapt_before;
    int done_before;

    initial begin
        rst = 1'b1; start_a = 8'h01; start_b = 8'h00; cfg_a = '0; cfg_b = 8'h81;
        cyc(4);
        rst = 1'b0;
        check("a_reset_pads", {sck_a, sda_a, scapt_a, preset_a, busy_a, done_a}, 0);
        check("b_reset_pads", {sck_b, sda_b, scapt_b, preset_b, busy_b, done_b}, 0);
        check("a_reset_count", cnt_a, 0);
        // start bit high through reset must not trigger
        cyc(6);
        check("a_held_start_no_trigger", busy_a, 0);
        start_a = 8'h00;
        cyc(2);

        // 1: byte0 = A5, rest zero
        cfg_a = 96'h0; cfg_a[7:0] = 8'hA5;
        push_frame_a(cfg_a, 8'd1);
        pulse_a();
        wait_a_done(2000);

        // 2: cfg changes mid-shift do not reach the frame in flight
        cfg_a = 96'h0123_4567_89AB_CDEF_5A3C_F00F;
        push_frame_a(cfg_a, 8'd2);
        pulse_a();
        cyc(400);
        cfg_a = {96{1'b1}};
        wait_a_done(2000);

        // 3: new edge at ~bit 40 while busy, then held high through DONE
        cfg_a = 96'hFEDC_BA98_7654_3210_C33C_9669;
        push_frame_a(cfg_a, 8'd3);
        start_a[0] = 1'b1;
        cyc(672);
        start_a[0] = 1'b0;
        cyc(1);
        start_a[0] = 1'b1;
        wait_a_done(2000);
        cyc(20);
        check("a_held_level_no_retrigger", busy_a, 0);
        check("a_count_after_held", cnt_a, 3);
        start_a[0] = 1'b0;
        cyc(2);
        push_frame_a(cfg_a, 8'd4);
        pulse_a();
        wait_a_done(2000);

        // 4: reset around bit 50 aborts the frame
        cfg_a = 96'h5555_AAAA_3333_CCCC_0F0F_F0F0;
        push_frame_a(cfg_a, 8'd5);
        scapt_before = a_scapt_total;
        pulse_a();
        begin
            int k = 0;
            while (exp_bits_a.size() != 46 && k < 2000) begin @(negedge clk); k++; end
            if (exp_bits_a.size() != 46) fail_now("a_bit50_timeout");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("a_abort_pads", {sck_a, sda_a, scapt_a, preset_a, busy_a, done_a}, 0);
        check("a_abort_count", cnt_a, 0);
        cyc(10);
        check("a_no_sck_after_abort", exp_bits_a.size(), 46);
        exp_bits_a.delete();
        exp_a.delete();
        cyc(2000);
        check("a_no_scapt_after_abort", a_scapt_total, scapt_before);
        check("a_idle_after_abort", busy_a, 0);
        check("a_count_stays_zero", cnt_a, 0);

        // 5: small configuration, data 0x81
        push_frame_b(8'd1);
        pulse_b();
        wait_done_b(100);
        cyc(2);
        // request raised in the DONE cycle is ignored
        push_frame_b(8'd2);
        pulse_b();
        wait_done_b(100);
        start_b[0] = 1'b1;
        cyc(10);
        check("b_done_cycle_req_ignored", busy_b, 0);
        check("b_expect_queue_drained", exp_b.size(), 0);
        start_b[0] = 1'b0;
        cyc(2);

        // 6: 256 back-to-back frames from a cleared count, restart on first IDLE cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        done_before = b_done_total;
        for (int i = 0; i < 256; i++) push_frame_b(8'((i + 1) % 256));
        pulse_b();
        for (int i = 0; i < 256; i++) begin
            wait_done_b(100);
            @(negedge clk);
            if (i != 255) begin
                start_b[0] = 1'b1;
                @(negedge clk);
                start_b[0] = 1'b0;
            end
        end
        cyc(10);
        check("b_count_wrapped", cnt_b, 0);
        check("b_done_pulses", b_done_total - done_before, 256);
        check("b_all_frames_seen", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
